// File: rtl/conv3x3_relu.sv
// conv3x3_relu: single-channel 3x3 cross-correlation, ReLU and 4-bit requant.
// Zero-padded, one output pixel per clock, start/done handshake.
module conv3x3_relu #(
    parameter int IMG_SIZE    = 16,
    parameter int SHIFT       = 2,
    parameter int INPUT_BITS  = IMG_SIZE*IMG_SIZE*4,
    parameter int OUTPUT_BITS = IMG_SIZE*IMG_SIZE*4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INPUT_BITS-1:0]  input_matrix,
    input  logic [35:0]            kernel,
    output logic [OUTPUT_BITS-1:0] output_matrix,
    output logic                   done,
    output logic                   busy
);

    localparam int CW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, next;

    logic [INPUT_BITS-1:0]  img_q;
    logic [35:0]            ker_q;
    logic [OUTPUT_BITS-1:0] out_q;
    logic [CW-1:0]          row, col;
    logic                   last_col, last_pix;

    logic signed [11:0] acc;
    logic signed [4:0]  px;
    logic signed [3:0]  kt;
    logic signed [8:0]  prod;
    logic [11:0]        t;
    logic [3:0]         res;
    int                 rr, cc;

    assign last_col = (col == CW'(IMG_SIZE-1));
    assign last_pix = last_col && (row == CW'(IMG_SIZE-1));

    // Neighbours outside the map contribute zero.
    always_comb begin
        acc  = '0;
        px   = '0;
        kt   = '0;
        prod = '0;
        rr   = 0;
        cc   = 0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                rr = int'(row) + ky - 1;
                cc = int'(col) + kx - 1;
                px = '0;
                if (rr >= 0 && rr < IMG_SIZE && cc >= 0 && cc < IMG_SIZE)
                    px = {1'b0, img_q[(rr*IMG_SIZE+cc)*4 +: 4]};
                kt   = ker_q[(ky*3+kx)*4 +: 4];
                prod = px * kt;
                acc  = acc + {{3{prod[8]}}, prod};
            end
        end
    end

    always_comb begin
        t   = acc[11:0] >> SHIFT;
        res = '0;
        if (!acc[11])
            res = (t > 12'd15) ? 4'hf : t[3:0];
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: if (start) next = RUN;
            RUN:  if (last_pix) next = DONE;
            DONE: if (!start) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            img_q <= '0;
            ker_q <= '0;
            out_q <= '0;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= next;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        img_q <= input_matrix;
                        ker_q <= kernel;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                RUN: begin
                    out_q[(int'(row)*IMG_SIZE+int'(col))*4 +: 4] <= res;
                    col <= last_col ? '0 : col + 1'b1;
                    if (last_col)
                        row <= row + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign output_matrix = out_q;
    assign done          = (state == DONE);
    assign busy          = (state == RUN);

endmodule

// File: doc/conv3x3_relu.md
# conv3x3_relu

Single-channel 3x3 convolution stage with ReLU and 4-bit requantisation. It sits directly upstream of `pooling`, consumes a flattened IMG_SIZE x IMG_SIZE map of 4-bit unsigned pixels, and produces a same-size 4-bit feature map in `pooling`'s packed format. Control is the same start/done handshake as `pooling`, so the two blocks chain without glue logic. It computes one output pixel per clock.

## Interface
- IMG_SIZE, 16, image edge length; input and output maps are both IMG_SIZE x IMG_SIZE.
- SHIFT, 2, right-shift applied to the non-negative accumulator before clamping.
- INPUT_BITS, IMG_SIZE*IMG_SIZE*4, width of the packed input map.
- OUTPUT_BITS, IMG_SIZE*IMG_SIZE*4, width of the packed output map.
- clk  input  1  the single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level request; sampled only in IDLE.
- input_matrix  input  INPUT_BITS  pixel (r,c) at bits [(r*IMG_SIZE+c)*4 +: 4], unsigned.
- kernel  input  36  tap (ky,kx) at bits [(ky*3+kx)*4 +: 4], two's-complement -8..7, with ky,kx in 0..2.
- output_matrix  output  OUTPUT_BITS  result pixel (r,c) at bits [(r*IMG_SIZE+c)*4 +: 4], registered.
- done  output  1  result complete and stable.
- busy  output  1  high while in RUN.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - When start=1: latch input_matrix and kernel into internal registers, clear the row/col counters, go to RUN.
  - output_matrix is not cleared here; it holds the previous result until overwritten.
- **RUN**
  - Each cycle computes the pixel at the current (row,col) from the latched copies.
  - It writes that pixel's 4-bit slot, then advances col. When col wraps to 0, row increments.
  - After writing pixel (IMG_SIZE-1, IMG_SIZE-1), go to DONE.
  - start is ignored in RUN. Changes on input_matrix and kernel after the latch have no effect.
- **DONE**
  - done=1 while start remains 1; there is no automatic restart.
  - When start=0, go to IDLE.
- **Arithmetic (per pixel)**
  - acc = sum over ky,kx of in(row+ky-1, col+kx-1) * k(ky,kx). This is cross-correlation; the kernel is not flipped.
  - Out-of-range coordinates read 0 (zero padding).
  - Each product is pixel zero-extended to 5 bits times signed 4-bit, giving range -120..105.
  - acc is 12-bit signed, range -1080..945, so no overflow is possible.
  - If acc<0, the result is 0. Otherwise t = acc >> SHIFT and the result is min(t,15).
- **Reset** (rst=1, at any time including mid-RUN)
  - Next edge: state IDLE, counters 0, output_matrix all 0, done=0, busy=0, latched registers 0.
  - rst has priority over start.

## Timing
- The edge that samples start=1 in IDLE is edge 0. busy=1 from edge 0 onward.
- Pixel p (p = r*IMG_SIZE+c) is written at edge p+1.
- done rises, and busy falls, at edge IMG_SIZE*IMG_SIZE (256 at default size), together with the final pixel write.
- Every output_matrix slot is valid whenever done=1.
- Total latency from start sampled to done is IMG_SIZE*IMG_SIZE cycles.
- start falling while done=1 gives done=0 one edge later (back in IDLE).
- Minimum restart gap: start=1 at the edge after IDLE is re-entered.
- start=1 held continuously through DONE does not restart; start must fall first.
- The pixel path is combinational within one cycle: 9 products into an adder tree, then ReLU and clamp, then the register. Pipelining it is allowed only if the latency above is preserved exactly.

## Test plan
- Identity kernel (centre tap 1, others 0), SHIFT=0, input pixel (r,c) = (r+c)%16, start held 1 → output equals input bit-for-bit; done rises exactly 256 cycles after start is sampled; busy is 1 for exactly those 256 cycles.
- All-ones kernel, SHIFT=0, all-1 image → interior pixels 9, edge pixels 6, corner pixels 4.
- All-ones kernel, SHIFT=2, all-2 image → interior pixels 4 (18>>2), edge pixels 3 (12>>2), corner pixels 2 (8>>2). All-15 image with the same kernel and shift → all pixels clamp to 15.
- Centre tap -8, others 0, all-5 image → every output pixel 0 (ReLU); done still rises at 256.
- Assert rst for one cycle at cycle 100 of RUN → next edge: done=0, busy=0, output_matrix=0, state IDLE. A following start with the identity kernel completes in 256 cycles with the correct image.
- Change input_matrix and kernel to all-0 one cycle after start is sampled → result still matches the originally latched data. Hold start=1 for 20 cycles after done → done stays 1, no recompute, output stable. Drop start → done=0 next edge.
